// File: rtl/sonar_medida_uc.sv
// Control unit for one ultrasonic distance measurement: clear, trigger, wait for echo,
// time the echo through contador_cm, then load the result register. Missing/stuck echo -> erro.
module sonar_medida_uc #(
    parameter int TRIGGER_CYCLES = 500,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       medir,
    input  logic       echo,
    input  logic       fim_medida,
    output logic       zera,
    output logic       trigger,
    output logic       registra,
    output logic       pronto,
    output logic       erro,
    output logic [3:0] db_estado
);

    localparam int TRIG_W = $clog2(TRIGGER_CYCLES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIGGER_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        INICIAL       = 4'b0000,
        PREPARACAO    = 4'b0001,
        ENVIA_TRIGGER = 4'b0010,
        ESPERA_ECHO   = 4'b0011,
        MEDIDA        = 4'b0100,
        ARMAZENAMENTO = 4'b0101,
        FINAL_MEDIDA  = 4'b0110,
        FALHA         = 4'b0111
    } estado_t;

    estado_t           estado_r;
    logic [TRIG_W-1:0] cnt_trig_r;
    logic [TMO_W-1:0]  cnt_tmo_r;
    logic              erro_r;

    function automatic logic [TRIG_W-1:0] sat_inc_trig(input logic [TRIG_W-1:0] v);
        if (v == {TRIG_W{1'b1}}) begin
            return v;
        end else begin
            return v + TRIG_W'(1);
        end
    endfunction

    function automatic logic [TMO_W-1:0] sat_inc_tmo(input logic [TMO_W-1:0] v);
        if (v == {TMO_W{1'b1}}) begin
            return v;
        end else begin
            return v + TMO_W'(1);
        end
    endfunction

    // Sequencing FSM with its trigger/timeout counters and the sticky error flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_r   <= INICIAL;
            cnt_trig_r <= '0;
            cnt_tmo_r  <= '0;
            erro_r     <= 1'b0;
        end else begin
            case (estado_r)
                INICIAL: begin
                    if (medir) begin
                        estado_r <= PREPARACAO;
                    end else begin
                        estado_r <= INICIAL;
                    end
                end
                PREPARACAO: begin
                    cnt_trig_r <= '0;
                    cnt_tmo_r  <= '0;
                    erro_r     <= 1'b0;
                    estado_r   <= ENVIA_TRIGGER;
                end
                ENVIA_TRIGGER: begin
                    cnt_trig_r <= sat_inc_trig(cnt_trig_r);
                    if (cnt_trig_r == TRIG_LAST) begin
                        estado_r <= ESPERA_ECHO;
                    end else begin
                        estado_r <= ENVIA_TRIGGER;
                    end
                end
                // Echo has priority over a timeout expiring in the same cycle.
                ESPERA_ECHO: begin
                    cnt_tmo_r <= sat_inc_tmo(cnt_tmo_r);
                    if (echo) begin
                        estado_r <= MEDIDA;
                    end else if (cnt_tmo_r == TMO_LAST) begin
                        estado_r <= FALHA;
                    end else begin
                        estado_r <= ESPERA_ECHO;
                    end
                end
                MEDIDA: begin
                    cnt_tmo_r <= sat_inc_tmo(cnt_tmo_r);
                    if (fim_medida) begin
                        estado_r <= ARMAZENAMENTO;
                    end else if (cnt_tmo_r == TMO_LAST) begin
                        estado_r <= FALHA;
                    end else begin
                        estado_r <= MEDIDA;
                    end
                end
                ARMAZENAMENTO: begin
                    estado_r <= FINAL_MEDIDA;
                end
                FINAL_MEDIDA: begin
                    estado_r <= INICIAL;
                end
                FALHA: begin
                    erro_r   <= 1'b1;
                    estado_r <= INICIAL;
                end
                default: begin
                    estado_r <= INICIAL;
                end
            endcase
        end
    end

    // Moore output decode straight from the state register, so reset drops them at once.
    always_comb begin
        zera     = 1'b0;
        trigger  = 1'b0;
        registra = 1'b0;
        pronto   = 1'b0;
        case (estado_r)
            PREPARACAO:    zera     = 1'b1;
            ENVIA_TRIGGER: trigger  = 1'b1;
            ARMAZENAMENTO: registra = 1'b1;
            FINAL_MEDIDA:  pronto   = 1'b1;
            default: begin
                zera     = 1'b0;
                trigger  = 1'b0;
                registra = 1'b0;
                pronto   = 1'b0;
            end
        endcase
    end

    assign erro      = erro_r;
    assign db_estado = estado_r;

endmodule

// File: tb/tb_sonar_medida_uc.sv
// Directed bench for sonar_medida_uc: an elapsed-time measurement model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_sonar_medida_uc;

    localparam int TRIG = 5;
    localparam int TMO  = 40;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       medir = 1'b0;
    logic       echo = 1'b0;
    logic       fim_medida = 1'b0;
    logic       zera, trigger, registra, pronto, erro;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;
    int st_cnt[8];
    int pronto_cnt = 0;
    int registra_cnt = 0;

    sonar_medida_uc #(.TRIGGER_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .medir(medir), .echo(echo), .fim_medida(fim_medida),
        .zera(zera), .trigger(trigger), .registra(registra), .pronto(pronto),
        .erro(erro), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Model: t = cycles since the request was accepted, w = cycles spent waiting for/timing echo.
    typedef struct packed {
        logic act;
        int   t;
        int   w;
        logic med;
        int   done;
        logic fail;
        logic err;
    } model_t;

    model_t m = '0;

    function automatic model_t step(input model_t x, input logic md, input logic ec, input logic fm);
        model_t n = x;
        if (!x.act) begin
            if (md) begin
                n = '0;
                n.act = 1'b1;
                n.err = x.err;
            end
        end else if (x.done == 1) begin
            n.done = 2;
        end else if (x.done == 2) begin
            n.act = 1'b0;
        end else if (x.fail) begin
            n.act = 1'b0;
            n.err = 1'b1;
        end else if (x.t <= TRIG) begin
            if (x.t == 0) n.err = 1'b0;
            n.t = x.t + 1;
        end else begin
            if (!x.med && ec)               n.med  = 1'b1;
            else if (x.med && fm)           n.done = 1;
            else if (x.w == TMO - 1)        n.fail = 1'b1;
            n.w = x.w + 1;
        end
        return n;
    endfunction

    function automatic logic [8:0] exp_out(input model_t x);
        logic [3:0] st = 4'd0;
        logic z = 1'b0, tr = 1'b0, r = 1'b0, p = 1'b0;
        if (x.act) begin
            if (x.done == 1)      begin st = 4'd5; r = 1'b1; end
            else if (x.done == 2) begin st = 4'd6; p = 1'b1; end
            else if (x.fail)      st = 4'd7;
            else if (x.t == 0)    begin st = 4'd1; z = 1'b1; end
            else if (x.t <= TRIG) begin st = 4'd2; tr = 1'b1; end
            else                  st = x.med ? 4'd4 : 4'd3;
        end
        return {z, tr, r, p, x.err, st};
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) m <= '0;
        else        m <= step(m, medir, echo, fim_medida);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, plus occupancy counters for literal checks.
    always @(negedge clock) begin
        check("cycle_model", {23'd0, zera, trigger, registra, pronto, erro, db_estado},
              {23'd0, exp_out(m)});
        if (db_estado[3] == 1'b0) st_cnt[db_estado[2:0]]++;
        if (pronto === 1'b1)   pronto_cnt++;
        if (registra === 1'b1) registra_cnt++;
    end

    task automatic clear_counts();
        for (int i = 0; i < 8; i++) st_cnt[i] = 0;
        pronto_cnt = 0;
        registra_cnt = 0;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int n = 0;
        while (db_estado !== s && n < budget) begin
            cyc();
            n++;
        end
        check(name, {28'd0, db_estado}, {28'd0, s});
    endtask

    task automatic start();
        medir = 1'b1;
        cyc();
        medir = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with random inputs
        clear_counts();
        cyc();
        for (int i = 0; i < 5; i++) begin
            medir = 1'($urandom_range(0, 1));
            echo = 1'($urandom_range(0, 1));
            fim_medida = 1'($urandom_range(0, 1));
            cyc();
            check("reset_outputs", {23'd0, zera, trigger, registra, pronto, erro, db_estado}, 32'd0);
        end
        medir = 1'b0; echo = 1'b0; fim_medida = 1'b0;
        reset = 1'b1;
        repeat (10) cyc();
        check("idle_stays_inicial", {28'd0, db_estado}, 32'd0);

        // Nominal measurement
        clear_counts();
        start();
        check("zera_in_prep", {31'd0, zera}, 32'd1);
        cyc();
        check("trigger_rises", {31'd0, trigger}, 32'd1);
        wait_state(4'd3, 20, "reach_espera");
        repeat (8) cyc();
        echo = 1'b1;
        repeat (12) cyc();
        echo = 1'b0;
        repeat (2) cyc();
        fim_medida = 1'b1;
        cyc();
        fim_medida = 1'b0;
        check("registra_after_fim", {31'd0, registra}, 32'd1);
        cyc();
        check("pronto_after_registra", {31'd0, pronto}, 32'd1);
        cyc();
        check("nominal_back_inicial", {28'd0, db_estado}, 32'd0);
        check("nominal_trigger_len", st_cnt[2], 5);
        check("nominal_zera_len", st_cnt[1], 1);
        check("nominal_espera_len", st_cnt[3], 9);
        check("nominal_medida_len", st_cnt[4], 14);
        check("nominal_pronto_cnt", pronto_cnt, 1);
        check("nominal_erro", {31'd0, erro}, 32'd0);

        // No echo: timeout from espera_echo
        clear_counts();
        start();
        wait_state(4'd3, 20, "noecho_reach_espera");
        wait_state(4'd7, 60, "noecho_reach_falha");
        cyc();
        check("noecho_erro_set", {31'd0, erro}, 32'd1);
        repeat (5) cyc();
        check("noecho_erro_sticky", {31'd0, erro}, 32'd1);
        check("noecho_espera_len", st_cnt[3], 40);
        check("noecho_no_pronto", pronto_cnt, 0);
        check("noecho_no_registra", registra_cnt, 0);
        start();
        cyc();
        check("erro_cleared_by_medir", {31'd0, erro}, 32'd0);

        // Stuck echo: timeout in medida
        clear_counts();
        wait_state(4'd3, 20, "stuck_reach_espera");
        repeat (9) cyc();
        echo = 1'b1;
        wait_state(4'd7, 60, "stuck_reach_falha");
        echo = 1'b0;
        cyc();
        check("stuck_erro_set", {31'd0, erro}, 32'd1);
        check("stuck_espera_len", st_cnt[3], 10);
        check("stuck_medida_len", st_cnt[4], 30);

        // Tie: echo on the terminal espera_echo cycle
        clear_counts();
        start();
        wait_state(4'd3, 20, "tie_echo_reach_espera");
        repeat (39) cyc();
        echo = 1'b1;
        cyc();
        echo = 1'b0;
        check("tie_echo_wins", {28'd0, db_estado}, 32'd4);
        fim_medida = 1'b1;
        cyc();
        fim_medida = 1'b0;
        check("tie_echo_armazena", {28'd0, db_estado}, 32'd5);
        repeat (2) cyc();
        check("tie_echo_no_falha", st_cnt[7], 0);
        check("tie_echo_pronto", pronto_cnt, 1);
        check("tie_echo_erro_clear", {31'd0, erro}, 32'd0);

        // Tie: fim_medida on the terminal medida cycle; echo already high on entry
        clear_counts();
        echo = 1'b1;
        start();
        wait_state(4'd4, 20, "preheld_echo_medida");
        check("preheld_espera_len", st_cnt[3], 1);
        echo = 1'b0;
        repeat (38) cyc();
        fim_medida = 1'b1;
        cyc();
        fim_medida = 1'b0;
        check("tie_fim_wins", {28'd0, db_estado}, 32'd5);
        repeat (2) cyc();
        check("tie_fim_no_falha", st_cnt[7], 0);
        check("tie_fim_pronto", pronto_cnt, 1);

        // medir during medida is ignored
        clear_counts();
        start();
        wait_state(4'd3, 20, "ignore_reach_espera");
        echo = 1'b1;
        cyc();
        medir = 1'b1;
        cyc();
        medir = 1'b0;
        echo = 1'b0;
        repeat (3) cyc();
        fim_medida = 1'b1;
        cyc();
        fim_medida = 1'b0;
        repeat (4) cyc();
        check("ignore_single_pronto", pronto_cnt, 1);
        check("ignore_single_prep", st_cnt[1], 1);
        check("ignore_back_inicial", {28'd0, db_estado}, 32'd0);

        // Reset on the 3rd trigger cycle
        clear_counts();
        start();
        repeat (3) cyc();
        check("midreset_trigger_before", {31'd0, trigger}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midreset_trigger_async", {31'd0, trigger}, 32'd0);
        check("midreset_state", {28'd0, db_estado}, 32'd0);
        cyc();
        reset = 1'b1;
        repeat (10) cyc();
        check("midreset_no_registra", registra_cnt, 0);
        check("midreset_no_pronto", pronto_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sonar_medida_uc.md
Name: sonar_medida_uc

Overview:
- Control unit that sequences one ultrasonic distance measurement end-to-end.
- Sequence per request: clears the cm counter datapath, emits the sensor trigger pulse, waits for the echo, lets the cm counter run while echo is high, then commands the result register load.
- Enforces a timeout for a missing echo or an echo stuck high.
- Sits above the cm counter (contador_cm) and its result register inside the sonar interface.

Parameters:
- TRIGGER_CYCLES, 500, trigger high time in clock cycles (10 us at 50 MHz).
- TIMEOUT_CYCLES, 1500000, maximum cycles spent in espera_echo plus medida combined (30 ms at 50 MHz).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- medir  in  1  measurement request, level-sampled in inicial.
- echo  in  1  sensor echo, already synchronised to clock upstream. Also drives pulso of contador_cm.
- fim_medida  in  1  pronto from contador_cm.
- zera  out  1  clears contador_cm and the timeout counter.
- trigger  out  1  sensor trigger pulse.
- registra  out  1  load enable for the distance result register.
- pronto  out  1  one-cycle measurement-done strobe.
- erro  out  1  sticky timeout flag.
- db_estado  out  4  current state code for debug.

Behaviour:
- Reset (reset=0): state goes to inicial immediately, independent of clock. All counters clear to 0, erro=0, and all outputs go low. db_estado=0000.
- Outputs are Moore, decoded from the state register only. erro is the only registered output.
- Internal counters:
  - Trigger counter, width $clog2(TRIGGER_CYCLES+1).
  - Timeout counter, width $clog2(TIMEOUT_CYCLES+1).
  - Both saturate; neither wraps.
- States (code), outputs, transitions:
  - inicial (0000): all outputs 0. Goes to preparacao if medir=1, else stays.
  - preparacao (0001): zera=1. Clears both counters and clears erro. Goes to envia_trigger unconditionally (1 cycle).
  - envia_trigger (0010): trigger=1 and the trigger counter increments. Goes to espera_echo when the count reaches TRIGGER_CYCLES-1, giving trigger high for exactly TRIGGER_CYCLES cycles.
  - espera_echo (0011): timeout counter increments.
    - echo=1: go to medida.
    - Else, if the count equals TIMEOUT_CYCLES-1: go to falha.
  - medida (0100): timeout counter keeps incrementing.
    - fim_medida=1: go to armazenamento.
    - Else, if the count equals TIMEOUT_CYCLES-1: go to falha.
  - armazenamento (0101): registra=1 for 1 cycle, then go to final_medida.
  - final_medida (0110): pronto=1 for 1 cycle, then go to inicial.
  - falha (0111): sets erro=1, then goes to inicial. pronto stays 0 and registra stays 0.
  - Undefined codes go to inicial.
- Latency: medir accepted → trigger rises 2 cycles later. fim_medida seen → registra next cycle → pronto the cycle after.
- Simultaneous events:
  - echo and timeout terminal in the same cycle: echo wins.
  - fim_medida and timeout terminal in the same cycle: fim_medida wins.
- medir is ignored in every state other than inicial; there is no queuing.
- medir held high continuously: a new measurement starts on the cycle after final_medida or falha, once back in inicial.
- erro holds until the next accepted medir. It is cleared in preparacao.
- Reset asserted mid-measurement, e.g. during envia_trigger: trigger drops asynchronously and no registra or pronto is produced.
- echo already high on entry to espera_echo: go to medida on the first espera_echo cycle.

Test Plan (bench uses TRIGGER_CYCLES=5, TIMEOUT_CYCLES=40):
1. Reset: hold reset=0 with random inputs → all outputs 0, db_estado=0000. Release reset, medir=0 for 10 cycles → stays in inicial.
2. Nominal: medir=1 for 1 cycle → zera=1 for 1 cycle, then trigger=1 for exactly 5 cycles. Raise echo 8 cycles later and hold it 12 cycles; pulse fim_medida 2 cycles after echo falls → registra for 1 cycle, pronto for 1 cycle on the next cycle, erro=0, back to inicial.
3. No echo: medir=1 and echo held 0 → falha after exactly 40 cycles in espera_echo. erro=1 and stays 1. pronto is never asserted. The next medir clears erro during preparacao.
4. Stuck echo: echo rises 10 cycles into espera_echo and never falls → falha after 30 cycles in medida (40 total). erro=1.
5. Tie cases:
   - echo=1 on espera_echo cycle 40 → medida, no falha.
   - fim_medida=1 on the terminal medida cycle → armazenamento.
6. Robustness:
   - medir pulsed during medida → ignored, exactly one pronto.
   - reset=0 on the 3rd trigger cycle → trigger=0 the same cycle, state inicial, no registra.
